// File: rtl/uart_tx_pkg.sv
// Shared UART definitions: frame state encoding, data width and default baud divide.
// The receive side imports this package as well.
package uart_tx_pkg;

  localparam int DATA_WIDTH           = 8;
  localparam int DEFAULT_CLOCK_DIVIDE = 104;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

endpackage

// File: rtl/uart_tx_if.sv
// Byte handshake between the command controller (master) and the UART transmitter (slave).
interface uart_tx_if;

  logic                              transmit;
  logic [uart_tx_pkg::DATA_WIDTH-1:0] tx_byte;
  logic                              is_transmitting;
  logic                              tx_dropped;

  modport master (
    output transmit,
    output tx_byte,
    input  is_transmitting,
    input  tx_dropped
  );

  modport slave (
    input  transmit,
    input  tx_byte,
    output is_transmitting,
    output tx_dropped
  );

endinterface

// File: rtl/uart_baud_counter.sv
// Bit-period divider: counts 0..CLOCK_DIVIDE-1 and flags the last cycle of each bit period.
// A restart forces the count back to zero so every frame state begins on a full bit period.
module uart_baud_counter
  import uart_tx_pkg::*;
#(
  parameter int CLOCK_DIVIDE = DEFAULT_CLOCK_DIVIDE
) (
  input  logic clock,
  input  logic reset_n,
  input  logic restart,
  output logic tick
);

  localparam int DIV_W = (CLOCK_DIVIDE > 1) ? $clog2(CLOCK_DIVIDE) : 1;
  localparam logic [DIV_W-1:0] LAST_COUNT = DIV_W'(CLOCK_DIVIDE - 1);

  logic [DIV_W-1:0] divider;

  assign tick = (divider == LAST_COUNT);

  // Advance the divider, wrapping at the bit boundary or on an explicit restart.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      divider <= '0;
    end else if (restart || tick) begin
      divider <= '0;
    end else begin
      divider <= divider + DIV_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: accepts a byte on a one-cycle strobe and shifts it out LSB-first.
// Strobes that arrive while a frame is in flight are dropped and reported on tx_dropped.
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int CLOCK_DIVIDE = DEFAULT_CLOCK_DIVIDE,
  parameter int STOP_BITS    = 1
) (
  input  logic       clock,
  input  logic       reset_n,
  uart_tx_if.slave   bus,
  output logic       tx
);

  localparam logic [2:0] LAST_DATA_BIT = 3'd7;
  localparam logic [2:0] LAST_STOP_BIT = 3'(STOP_BITS - 1);

  uart_state_t           state;
  uart_state_t           state_next;
  logic [DATA_WIDTH-1:0] shift;
  logic [DATA_WIDTH-1:0] shift_next;
  logic [2:0]            bit_cnt;
  logic [2:0]            bit_cnt_next;
  logic                  tx_next;
  logic                  tick;
  logic                  restart;

  uart_baud_counter #(
    .CLOCK_DIVIDE(CLOCK_DIVIDE)
  ) u_baud (
    .clock   (clock),
    .reset_n (reset_n),
    .restart (restart),
    .tick    (tick)
  );

  assign bus.is_transmitting = (state != IDLE);

  // Next-state, shift register and line-level decode; tx is computed one cycle ahead so it can be registered.
  always_comb begin
    state_next   = state;
    shift_next   = shift;
    bit_cnt_next = bit_cnt;
    tx_next      = 1'b1;
    case (state)
      IDLE: begin
        if (bus.transmit) begin
          state_next   = START;
          shift_next   = bus.tx_byte;
          bit_cnt_next = '0;
        end
      end
      START: begin
        if (tick) begin
          state_next   = DATA;
          bit_cnt_next = '0;
        end
      end
      DATA: begin
        if (tick) begin
          if (bit_cnt == LAST_DATA_BIT) begin
            state_next   = STOP;
            bit_cnt_next = '0;
          end else begin
            shift_next   = {1'b0, shift[DATA_WIDTH-1:1]};
            bit_cnt_next = bit_cnt + 3'd1;
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (bit_cnt == LAST_STOP_BIT) begin
            state_next   = IDLE;
            bit_cnt_next = '0;
          end else begin
            bit_cnt_next = bit_cnt + 3'd1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_next[0];
      default: tx_next = 1'b1;
    endcase
    restart = (state_next != state) || (state == IDLE);
  end

  // Frame state, shifter, serial line and drop flag; reset aborts any frame and forces the line high.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state          <= IDLE;
      shift          <= '0;
      bit_cnt        <= '0;
      tx             <= 1'b1;
      bus.tx_dropped <= 1'b0;
    end else begin
      state          <= state_next;
      shift          <= shift_next;
      bit_cnt        <= bit_cnt_next;
      tx             <= tx_next;
      bus.tx_dropped <= bus.transmit && (state != IDLE);
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: a table of frames on a CLOCK_DIVIDE=4 / 1 stop-bit instance,
// plus hand sequences for reset mid-frame and a CLOCK_DIVIDE=3 / 2 stop-bit instance.
module tb_uart_tx;
  import uart_tx_pkg::*;

  localparam int CD_A    = 4;
  localparam int SB_A    = 1;
  localparam int CD_B    = 3;
  localparam int SB_B    = 2;
  localparam int FRAME_A = (9 + SB_A) * CD_A;
  localparam int FRAME_B = (9 + SB_B) * CD_B;

  logic clock = 1'b0;
  logic reset_n;
  logic tx_a;
  logic tx_b;

  int checks = 0;
  int passes = 0;

  uart_tx_if bus_a ();
  uart_tx_if bus_b ();

  uart_tx #(.CLOCK_DIVIDE(CD_A), .STOP_BITS(SB_A)) dut_a (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus_a),
    .tx      (tx_a)
  );

  uart_tx #(.CLOCK_DIVIDE(CD_B), .STOP_BITS(SB_B)) dut_b (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus_b),
    .tx      (tx_b)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] data;
    logic [7:0] exp_decoded;
    int         exp_busy;
    int         strobe_at;
    logic [7:0] strobe_byte;
    bit         back_to_back;
  } frame_vec_t;

  frame_vec_t vecs [6];

  // Expected line level k cycles after the accepting edge (k=1 is the first start-bit cycle).
  function automatic logic model_tx(input logic [7:0] d, input int cd, input int sb, input int k);
    int idx;
    if (k < 1) return 1'b1;
    idx = (k - 1) / cd;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return d[idx-1];
    return 1'b1;
  endfunction

  task automatic step();
    @(negedge clock);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, actual, expected);
    end else begin
      passes++;
    end
  endtask

  task automatic applyStimulus(input logic strobe, input logic [7:0] data);
    bus_a.transmit = strobe;
    bus_a.tx_byte  = data;
  endtask

  // Steps n cycles, checking both instances sit idle.
  task automatic idle_check(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      checkOutput("idle tx_a",   32'(tx_a), 32'(1));
      checkOutput("idle busy_a", 32'(bus_a.is_transmitting), 32'(0));
      checkOutput("idle drop_a", 32'(bus_a.tx_dropped), 32'(0));
      checkOutput("idle tx_b",   32'(tx_b), 32'(1));
      checkOutput("idle busy_b", 32'(bus_b.is_transmitting), 32'(0));
    end
  endtask

  // Sends one frame on instance A and checks every cycle; returns at the first idle cycle.
  task automatic run_frame_a(input frame_vec_t v);
    int         busy;
    logic [7:0] decoded;
    int         bit_idx;
    busy    = 0;
    decoded = 8'h00;
    applyStimulus(1'b1, v.data);
    step();
    for (int k = 1; k <= FRAME_A; k++) begin
      checkOutput("frame tx",   32'(tx_a), 32'(model_tx(v.data, CD_A, SB_A, k)));
      checkOutput("frame busy", 32'(bus_a.is_transmitting), 32'(1));
      checkOutput("frame drop", 32'(bus_a.tx_dropped),
                  32'((v.strobe_at >= 0) && (k == v.strobe_at + 1)));
      if (bus_a.is_transmitting) busy++;
      bit_idx = (k - 1) / CD_A - 1;
      if ((bit_idx >= 0) && (bit_idx < 8) && (((k - 1) % CD_A) == CD_A / 2)) decoded[bit_idx] = tx_a;
      if (k == v.strobe_at) applyStimulus(1'b1, v.strobe_byte);
      else                  applyStimulus(1'b0, ~v.data);
      step();
    end
    checkOutput("end tx",   32'(tx_a), 32'(1));
    checkOutput("end busy", 32'(bus_a.is_transmitting), 32'(0));
    checkOutput("end drop", 32'(bus_a.tx_dropped), 32'(v.strobe_at == FRAME_A));
    checkOutput("busy length", 32'(busy), 32'(v.exp_busy));
    checkOutput("decoded byte", 32'(decoded), 32'(v.exp_decoded));
    applyStimulus(1'b0, 8'h00);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int busy;
    int stop_high;

    vecs[0] = '{8'h42, 8'h42, 40, -1, 8'h00, 1'b0};
    vecs[1] = '{8'hCD, 8'hCD, 40, -1, 8'h00, 1'b0};
    vecs[2] = '{8'h0E, 8'h0E, 40, -1, 8'h00, 1'b1};
    vecs[3] = '{8'h44, 8'h44, 40, 10, 8'hFF, 1'b0};
    vecs[4] = '{8'h81, 8'h81, 40, 1,  8'h7E, 1'b0};
    vecs[5] = '{8'hFF, 8'hFF, 40, 40, 8'h00, 1'b0};

    reset_n        = 1'b0;
    bus_b.transmit = 1'b0;
    bus_b.tx_byte  = 8'h00;
    applyStimulus(1'b0, 8'h00);
    step(); step(); step();
    checkOutput("reset tx_a",   32'(tx_a), 32'(1));
    checkOutput("reset busy_a", 32'(bus_a.is_transmitting), 32'(0));
    checkOutput("reset drop_a", 32'(bus_a.tx_dropped), 32'(0));
    checkOutput("reset tx_b",   32'(tx_b), 32'(1));
    checkOutput("reset busy_b", 32'(bus_b.is_transmitting), 32'(0));
    checkOutput("reset drop_b", 32'(bus_b.tx_dropped), 32'(0));
    reset_n = 1'b1;
    idle_check(20);

    for (int i = 0; i < 6; i++) begin
      if (!vecs[i].back_to_back) idle_check(2);
      run_frame_a(vecs[i]);
    end

    // Reset mid-frame with a coincident strobe: reset wins and nothing resumes.
    idle_check(2);
    applyStimulus(1'b1, 8'h00);
    step();
    applyStimulus(1'b0, 8'h00);
    for (int k = 1; k <= 15; k++) begin
      checkOutput("pre-reset tx",   32'(tx_a), 32'(model_tx(8'h00, CD_A, SB_A, k)));
      checkOutput("pre-reset busy", 32'(bus_a.is_transmitting), 32'(1));
      if (k < 15) step();
    end
    reset_n = 1'b0;
    applyStimulus(1'b1, 8'h3C);
    step();
    checkOutput("in-reset tx",   32'(tx_a), 32'(1));
    checkOutput("in-reset busy", 32'(bus_a.is_transmitting), 32'(0));
    checkOutput("in-reset drop", 32'(bus_a.tx_dropped), 32'(0));
    reset_n = 1'b1;
    applyStimulus(1'b0, 8'h00);
    step();
    checkOutput("post-reset tx",   32'(tx_a), 32'(1));
    checkOutput("post-reset busy", 32'(bus_a.is_transmitting), 32'(0));
    checkOutput("post-reset drop", 32'(bus_a.tx_dropped), 32'(0));
    idle_check(3);
    run_frame_a('{8'hA5, 8'hA5, 40, -1, 8'h00, 1'b0});
    idle_check(2);

    // Two stop bits at CLOCK_DIVIDE=3.
    busy      = 0;
    stop_high = 0;
    bus_b.transmit = 1'b1;
    bus_b.tx_byte  = 8'h10;
    step();
    bus_b.transmit = 1'b0;
    bus_b.tx_byte  = 8'hEF;
    for (int k = 1; k <= FRAME_B; k++) begin
      checkOutput("b tx",   32'(tx_b), 32'(model_tx(8'h10, CD_B, SB_B, k)));
      checkOutput("b busy", 32'(bus_b.is_transmitting), 32'(1));
      checkOutput("b drop", 32'(bus_b.tx_dropped), 32'(0));
      if (bus_b.is_transmitting) busy++;
      if ((k > 9 * CD_B) && (tx_b == 1'b1)) stop_high++;
      step();
    end
    checkOutput("b end tx",      32'(tx_b), 32'(1));
    checkOutput("b end busy",    32'(bus_b.is_transmitting), 32'(0));
    checkOutput("b busy length", 32'(busy), 32'(33));
    checkOutput("b stop high",   32'(stop_high), 32'(6));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- 8N1 UART transmitter; sits directly downstream of the command controller.
- Accepts a byte on a one-cycle `transmit` strobe and serialises it LSB-first on `tx`.
- Reports `is_transmitting` back so the controller can pace its reply bytes.
- Asserting `transmit` while a frame is in flight drops the byte; the drop is flagged on `tx_dropped`.

Parameters:
- CLOCK_DIVIDE, 104, clock cycles per bit period; legal range >= 2.
- STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
- clock  input  1  system clock; all logic on posedge.
- reset_n  input  1  synchronous, active-low reset.
- transmit  input  1  one-cycle strobe; send `tx_byte`.
- tx_byte  input  8  byte to send; sampled only in the cycle `transmit`=1 is accepted.
- tx  output  1  serial line; idle high.
- is_transmitting  output  1  high while a frame is in progress.
- tx_dropped  output  1  one-cycle pulse when `transmit` is ignored.

Behaviour:
- All ports are on one clock. Reset is synchronous and active-low (`reset_n` sampled on posedge `clock`).
- Reset values: tx=1, is_transmitting=0, tx_dropped=0, state=IDLE, bit counter=0, divider=0.
- States:
  - IDLE, START, DATA, STOP.
  - IDLE -> START on accepted transmit.
  - START -> DATA after CLOCK_DIVIDE cycles.
  - DATA -> STOP after 8 bit periods.
  - STOP -> IDLE after STOP_BITS*CLOCK_DIVIDE cycles.
- Accept:
  - `transmit`=1 in IDLE latches `tx_byte` into the shift register.
  - The next cycle has tx=0 and is_transmitting=1 (latency 1).
- Divider:
  - Counts 0..CLOCK_DIVIDE-1 and restarts at every state entry.
  - A bit boundary is when divider==CLOCK_DIVIDE-1.
  - Divider width is clog2(CLOCK_DIVIDE).
- DATA:
  - tx = shift[0]; shift right at each bit boundary.
  - 3-bit counter; leave DATA when count==7 at a boundary.
- STOP: tx=1 for STOP_BITS bit periods.
- is_transmitting: high for exactly (9+STOP_BITS)*CLOCK_DIVIDE consecutive cycles per frame; low in the first IDLE cycle.
- Back-to-back:
  - A strobe in the first cycle is_transmitting=0 is accepted.
  - Minimum frame-to-frame gap is therefore 1 idle-high cycle.
- Busy strobe:
  - `transmit`=1 when state!=IDLE is ignored; the frame in flight is unaffected.
  - tx_dropped=1 in the following cycle, for one cycle only.
- `tx_byte` changes while busy have no effect.
- Reset mid-frame:
  - Abort immediately; tx=1 in the cycle after reset is sampled.
  - No partial resumption after reset releases.
- Reset and `transmit` in the same cycle: reset wins; the byte is not sent and tx_dropped stays 0.
- `tx` is registered (no combinational path from inputs to `tx`).

Decomposition:
- Shared package/header uart_defs:
  - State encoding (IDLE=0, START=1, DATA=2, STOP=3).
  - Data width 8.
  - Default CLOCK_DIVIDE.
  - The same header is reused by the receive side.
- One natural sub-module, uart_baud_counter:
  - Parameter CLOCK_DIVIDE.
  - Inputs clock, reset_n, restart.
  - Output tick, high on the last cycle of each bit period.
- The FSM and shift register stay in uart_tx.

Test Plan (CLOCK_DIVIDE=4, STOP_BITS=1 unless stated):
- Reset then idle 20 cycles -> tx=1, is_transmitting=0, tx_dropped=0 throughout.
- Strobe transmit with 0x42 -> from next cycle tx holds 4 cycles each: 0 | 0,1,0,0,0,0,1,0 | 1; is_transmitting high exactly 40 cycles; tx_dropped never set.
- Send 0xCD, then strobe in the first cycle is_transmitting=0 with 0x0E -> second frame starts after exactly 1 idle cycle and decodes as 0x0E.
- During a 0x44 frame, strobe transmit with 0xFF at cycle 10 -> tx_dropped pulses one cycle at cycle 11; the line still decodes 0x44; is_transmitting length unchanged.
- Assert reset_n=0 at cycle 15 of a 0x00 frame -> tx=1 and is_transmitting=0 the next cycle; a following strobe of 0xA5 sends a clean full frame.
- STOP_BITS=2, CLOCK_DIVIDE=3, send 0x10 -> stop high 6 cycles; is_transmitting high 33 cycles.
